bp_cce_mem_cmd_packer: RTL
==========================

BP_CCE_MEM_CMD_PACKER -- requirements
Module: bp_cce_mem_cmd_packer

Interface
REQ-001 SHALL have parameter header_width_p, default 64; header width in bits.
REQ-002 SHALL have parameter data_width_p, default 64; burst beat width in bits.
REQ-003 SHALL have parameter block_width_p, default 512; packed block width in bits, an integer multiple of data_width_p.
REQ-004 SHALL derive max_beats = block_width_p/data_width_p (default 8) and cnt_width = clog2(max_beats) with a minimum of 1.
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n_i  in  1  reset, asynchronous and active-low.
REQ-007 mem_cmd_header_i  in  header_width_p  CCE mem command burst header.
REQ-008 mem_cmd_header_size_i  in  3  message size field of the header; bytes = 2^size.
REQ-009 mem_cmd_header_has_data_i  in  1  header is followed by data beats.
REQ-010 mem_cmd_header_v_i / mem_cmd_header_ready_and_o  in/out  1  header ready&valid handshake.
REQ-011 mem_cmd_data_i  in  data_width_p  burst data beat.
REQ-012 mem_cmd_data_v_i / mem_cmd_data_ready_and_o  in/out  1  data ready&valid handshake.
REQ-013 msg_header_o  out  header_width_p  registered header of the packed message.
REQ-014 msg_data_o  out  block_width_p  registered packed block.
REQ-015 msg_v_o / msg_ready_and_i  out/in  1  packed message ready&valid handshake.

Function
REQ-016 SHALL treat a transfer as occurring on a channel only in a cycle where that channel's v and ready_and are both 1.
REQ-017 SHALL implement the states READY, DATA, and SEND.
REQ-018 In READY: header_ready_and_o=1, data_ready_and_o=0, msg_v_o=0.
REQ-019 On a header transfer in READY: SHALL capture the header, clear msg_data_o to 0, and clear the beat counter to 0.
- On that transfer, SHALL go to DATA if has_data=1, else to SEND.
REQ-020 SHALL compute beats for a header as follows:
- size 0..3 -> 1;
- size 4 -> 2;
- size 5 -> 4;
- size >= 6 -> max_beats;
- the result is always capped at max_beats.
REQ-021 In DATA: data_ready_and_o=1, header_ready_and_o=0, msg_v_o=0.
- Each data transfer writes the beat into slice [cnt*data_width_p +: data_width_p] of msg_data_o and increments cnt.
REQ-022 On the data transfer where cnt == beats-1: SHALL go to SEND and hold cnt at that value.
- No further beats are accepted for that message.
REQ-023 Block bits above beats*data_width_p SHALL remain 0.
REQ-024 In SEND: msg_v_o=1 and both input ready_and outputs are 0.
- msg_header_o and msg_data_o SHALL hold stable until the output transfer.
REQ-025 On the output transfer: SHALL go to READY in the next cycle.
- No header is accepted in the same cycle as the output transfer.
REQ-026 Latency:
- header-only message: msg_v_o rises 1 cycle after the header transfer;
- data message: msg_v_o rises 1 cycle after the last beat transfer.
REQ-027 Data beats presented in READY or SEND SHALL NOT be consumed.
- Headers presented in DATA or SEND SHALL NOT be consumed.
REQ-028 Gaps between beats (data_v_i=0) SHALL stall DATA with no state change.
REQ-029 msg_ready_and_i held 0 SHALL hold SEND indefinitely with outputs unchanged.
REQ-030 Size and has_data SHALL be sampled only at the header transfer; later changes on those inputs are ignored.
REQ-031 All ready_and and v outputs SHALL be functions of state only, with no combinational path from any input.

Reset
REQ-032 While reset_n_i=0, asynchronously:
- state=READY, cnt=0;
- msg_header_o=0, msg_data_o=0, msg_v_o=0;
- data_ready_and_o=0; header_ready_and_o=1 once reset_n_i=1.
REQ-033 Reset asserted mid-DATA or mid-SEND SHALL discard the partial or pending message.
- After release, the next header transfer starts a fresh message.

Verification
REQ-034 Header-only: has_data=0, header=0x1234 -> next cycle msg_v_o=1, msg_header_o=0x1234, msg_data_o=0.
REQ-035 Full block: size=6 with beats 0x0..0x7 in 8 consecutive cycles -> msg_data_o slice k = k, msg_v_o=1 one cycle after beat 7.
REQ-036 Partial: size=4 with beats 0xAA, 0xBB -> slice0=0xAA, slice1=0xBB, slices 2..7=0; a third presented beat is not consumed.
REQ-037 Backpressure/bubbles: random data_v_i gaps and msg_ready_and_i=0 for 5 cycles -> outputs stable in SEND, exactly one output transfer per header.
REQ-038 Reset mid-DATA after 3 of 8 beats -> outputs 0 asynchronously; new size=3 message of 0xFF -> slice0=0xFF, rest 0.
REQ-039 Back-to-back headers with v held high -> second header is accepted only in the cycle after the first message's output transfer.

Source files
------------

// File: rtl/bp_cce_mem_cmd_packer_if.sv
// Bus bundle for the CCE memory command packer.
// Upstream side: a burst header channel and a data-beat channel.
// Downstream side: one packed message with its header and the full block.
// The packer connects through the slave modport. A driver or test harness
// connects through the master modport.
interface bp_cce_mem_cmd_packer_if #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int block_width_p  = 512
);
    // Burst header channel
    logic [header_width_p-1:0] mem_cmd_header_i;
    logic [2:0]                mem_cmd_header_size_i;
    logic                      mem_cmd_header_has_data_i;
    logic                      mem_cmd_header_v_i;
    logic                      mem_cmd_header_ready_and_o;

    // Burst data channel
    logic [data_width_p-1:0]   mem_cmd_data_i;
    logic                      mem_cmd_data_v_i;
    logic                      mem_cmd_data_ready_and_o;

    // Packed message channel
    logic [header_width_p-1:0] msg_header_o;
    logic [block_width_p-1:0]  msg_data_o;
    logic                      msg_v_o;
    logic                      msg_ready_and_i;

    // Packer side: consumes the burst and produces the packed message
    modport slave (
        input  mem_cmd_header_i,
        input  mem_cmd_header_size_i,
        input  mem_cmd_header_has_data_i,
        input  mem_cmd_header_v_i,
        output mem_cmd_header_ready_and_o,
        input  mem_cmd_data_i,
        input  mem_cmd_data_v_i,
        output mem_cmd_data_ready_and_o,
        output msg_header_o,
        output msg_data_o,
        output msg_v_o,
        input  msg_ready_and_i
    );

    // Driver side: produces the burst and consumes the packed message
    modport master (
        output mem_cmd_header_i,
        output mem_cmd_header_size_i,
        output mem_cmd_header_has_data_i,
        output mem_cmd_header_v_i,
        input  mem_cmd_header_ready_and_o,
        output mem_cmd_data_i,
        output mem_cmd_data_v_i,
        input  mem_cmd_data_ready_and_o,
        input  msg_header_o,
        input  msg_data_o,
        input  msg_v_o,
        output msg_ready_and_i
    );
endinterface

// File: rtl/bp_cce_mem_cmd_packer.sv
// CCE memory command packer.
// Collects one burst header and its data beats, and packs the beats into a
// single block-wide message. The message is held stable until the consumer
// accepts it. Only one message is in flight at a time.
// Every ready/valid output is a registered flag that tracks the FSM state.
// No input can reach these outputs through combinational logic.
module bp_cce_mem_cmd_packer #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int block_width_p  = 512
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    bp_cce_mem_cmd_packer_if.slave     bus
);

    localparam int max_beats_lp = block_width_p / data_width_p;
    localparam int cnt_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_DATA  = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    // Returns the index of the final beat for a given size field.
    // A message of 2^size bytes needs this many beats, capped to the block.
    function automatic logic [cnt_width_lp-1:0] last_beat_f(input logic [2:0] size);
        int beats_v;
        case (size)
            3'd0, 3'd1, 3'd2, 3'd3: beats_v = 1;
            3'd4:                   beats_v = 2;
            3'd5:                   beats_v = 4;
            default:                beats_v = max_beats_lp;
        endcase
        if (beats_v > max_beats_lp) begin
            beats_v = max_beats_lp;
        end else begin
            beats_v = beats_v;
        end
        return cnt_width_lp'(beats_v - 1);
    endfunction

    state_e                    state_r;
    state_e                    state_s;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic [cnt_width_lp-1:0]   last_r;
    logic [header_width_p-1:0] header_r;
    logic [block_width_p-1:0]  data_r;
    logic                      header_ready_r;
    logic                      data_ready_r;
    logic                      msg_v_r;

    logic                      header_fire_s;
    logic                      data_fire_s;
    logic                      msg_fire_s;
    logic                      last_beat_s;

    // A transfer happens only where valid meets our own registered ready.
    assign header_fire_s = bus.mem_cmd_header_v_i & header_ready_r;
    assign data_fire_s   = bus.mem_cmd_data_v_i   & data_ready_r;
    assign msg_fire_s    = bus.msg_ready_and_i    & msg_v_r;
    assign last_beat_s   = (cnt_r == last_r);

    // Holds the FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_READY;
        end else begin
            state_r <= state_s;
        end
    end

    // Selects the next state from the current state and the channel transfers
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_READY: begin
                if (header_fire_s) begin
                    if (bus.mem_cmd_header_has_data_i) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_DATA: begin
                if (data_fire_s && last_beat_s) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_SEND: begin
                if (msg_fire_s) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_READY;
            end
        endcase
    end

    // Registers the handshake flags from the next state so they always match the state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            header_ready_r <= 1'b1;
            data_ready_r   <= 1'b0;
            msg_v_r        <= 1'b0;
        end else begin
            header_ready_r <= (state_s == ST_READY);
            data_ready_r   <= (state_s == ST_DATA);
            msg_v_r        <= (state_s == ST_SEND);
        end
    end

    // Captures the header, writes beats into the block, and advances the beat counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r    <= '0;
            last_r   <= '0;
            header_r <= '0;
            data_r   <= '0;
        end else if (header_fire_s) begin
            // A new message starts from a clean block, so unused beats read as zero.
            header_r <= bus.mem_cmd_header_i;
            data_r   <= '0;
            cnt_r    <= '0;
            last_r   <= last_beat_f(bus.mem_cmd_header_size_i);
        end else if (data_fire_s) begin
            data_r[int'(cnt_r)*data_width_p +: data_width_p] <= bus.mem_cmd_data_i;
            // On the final beat the counter stays put. The FSM leaves DATA,
            // so no more beats are accepted.
            if (!last_beat_s) begin
                cnt_r <= cnt_r + cnt_width_lp'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r    <= cnt_r;
            last_r   <= last_r;
            header_r <= header_r;
            data_r   <= data_r;
        end
    end

    assign bus.mem_cmd_header_ready_and_o = header_ready_r;
    assign bus.mem_cmd_data_ready_and_o   = data_ready_r;
    assign bus.msg_v_o                    = msg_v_r;
    assign bus.msg_header_o               = header_r;
    assign bus.msg_data_o                 = data_r;

endmodule
